// File: rtl/move_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : move_ctrl
//  Purpose  : Tick-driven platformer movement: jump/fall FSM plus horizontal
//             stepping, emitting one-cycle position step pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module move_ctrl #(
    parameter int JUMP_H = 16,
    parameter int H_DIV  = 2
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    input  logic       solid_below,
    input  logic       solid_above,
    input  logic       solid_left,
    input  logic       solid_right,
    output logic [3:0] update_pos_scroll,
    output logic       jump,
    output logic       fall
);

    localparam int c_RISE_W = $clog2(JUMP_H + 1);
    localparam int c_H_W    = $clog2(H_DIV + 1);
    localparam logic [c_RISE_W-1:0] c_JUMP_H = c_RISE_W'(JUMP_H);
    localparam logic [c_H_W-1:0]    c_H_TOP  = c_H_W'(H_DIV - 1);

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_RISE_W-1:0]   r_rise_cnt;
    logic [c_RISE_W-1:0]   w_rise_cnt_nxt;
    logic [c_H_W-1:0]      r_h_cnt;
    logic [c_H_W-1:0]      w_h_cnt_nxt;
    logic                  r_jump_prev;
    logic                  r_seq_v;
    logic                  r_seq_h;
    logic [1:0]            r_h_pend;
    logic [1:0]            w_v_pulse;
    logic [1:0]            w_h_pulse;
    logic                  w_accept;

    // The sequencer is busy for the whole T+1/T+2 window of an accepted tick.
    assign w_accept = tick & ~r_seq_v & ~r_seq_h;

    always_comb begin
        w_state_nxt    = r_state;
        w_rise_cnt_nxt = r_rise_cnt;
        w_h_cnt_nxt    = r_h_cnt;
        w_v_pulse      = 2'b00;
        w_h_pulse      = 2'b00;
        if (w_accept) begin
            case (r_state)
                GROUND: begin
                    if (!solid_below) begin
                        w_state_nxt = FALL;
                    end else if (btn_jump && !r_jump_prev) begin
                        w_state_nxt    = RISE;
                        w_rise_cnt_nxt = '0;
                    end
                end
                RISE: begin
                    if (solid_above) begin
                        w_state_nxt = FALL;
                    end else begin
                        w_v_pulse      = 2'b10;
                        w_rise_cnt_nxt = r_rise_cnt + 1'b1;
                        if (w_rise_cnt_nxt == c_JUMP_H) begin
                            w_state_nxt = FALL;
                        end
                    end
                end
                FALL: begin
                    if (solid_below) begin
                        w_state_nxt = GROUND;
                    end else begin
                        w_v_pulse = 2'b01;
                    end
                end
                default: w_state_nxt = GROUND;
            endcase

            if (btn_left ^ btn_right) begin
                if (r_h_cnt == c_H_TOP) begin
                    w_h_cnt_nxt = '0;
                    w_h_pulse   = {btn_left & ~solid_left, btn_right & ~solid_right};
                end else begin
                    w_h_cnt_nxt = r_h_cnt + 1'b1;
                end
            end else begin
                w_h_cnt_nxt = '0;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= GROUND;
            jump              <= 1'b0;
            fall              <= 1'b0;
            r_rise_cnt        <= '0;
            r_h_cnt           <= '0;
            r_jump_prev       <= 1'b1;
            r_seq_v           <= 1'b0;
            r_seq_h           <= 1'b0;
            r_h_pend          <= 2'b00;
            update_pos_scroll <= 4'b0000;
        end else begin
            r_state    <= w_state_nxt;
            jump       <= (w_state_nxt == RISE);
            fall       <= (w_state_nxt == FALL);
            r_rise_cnt <= w_rise_cnt_nxt;
            r_h_cnt    <= w_h_cnt_nxt;
            r_seq_v    <= w_accept;
            r_seq_h    <= r_seq_v;
            if (w_accept) begin
                r_jump_prev       <= btn_jump;
                r_h_pend          <= w_h_pulse;
                update_pos_scroll <= {w_v_pulse, 2'b00};
            end else if (r_seq_v) begin
                update_pos_scroll <= {2'b00, r_h_pend};
            end else begin
                update_pos_scroll <= 4'b0000;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_move_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_move_ctrl
//  Purpose  : Randomized self-checking bench for move_ctrl against a
//             behavioural movement model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_move_ctrl;

    localparam int JUMP_H = 4;
    localparam int H_DIV  = 2;

    logic       sys_clk = 1'b0;
    logic       rst_n   = 1'b0;
    logic       tick    = 1'b0;
    logic       btn_left = 1'b0, btn_right = 1'b0, btn_jump = 1'b0;
    logic       solid_below = 1'b1, solid_above = 1'b0;
    logic       solid_left = 1'b0, solid_right = 1'b0;
    logic [3:0] update_pos_scroll;
    logic       jump;
    logic       fall;

    int n_vec = 0;
    int n_err = 0;

    move_ctrl #(.JUMP_H(JUMP_H), .H_DIV(H_DIV)) u_dut (
        .sys_clk           (sys_clk),
        .rst_n             (rst_n),
        .tick              (tick),
        .btn_left          (btn_left),
        .btn_right         (btn_right),
        .btn_jump          (btn_jump),
        .solid_below       (solid_below),
        .solid_above       (solid_above),
        .solid_left        (solid_left),
        .solid_right       (solid_right),
        .update_pos_scroll (update_pos_scroll),
        .jump              (jump),
        .fall              (fall)
    );

    always #5 sys_clk = ~sys_clk;

    // Model: 0 = on ground, 1 = rising, 2 = falling; outputs scheduled per cycle.
    int         m_state, m_rise, m_h, m_cyc = 0, m_last;
    logic       m_jp;
    logic [3:0] m_out;
    logic [3:0] m_sched[$];

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_state = 0;
        m_rise  = 0;
        m_h     = 0;
        m_jp    = 1'b1;
        m_out   = 4'h0;
        m_last  = m_cyc - 100;
        m_sched.delete();
    endfunction

    function automatic void model_step();
        logic [3:0] v, h;
        m_cyc++;
        m_out = (m_sched.size() > 0) ? m_sched.pop_front() : 4'h0;
        if (tick && (m_cyc - m_last >= 3)) begin
            m_last = m_cyc;
            v = 4'h0;
            h = 4'h0;
            if (m_state == 0) begin
                if (!solid_below) m_state = 2;
                else if (btn_jump && !m_jp) begin m_state = 1; m_rise = 0; end
            end else if (m_state == 1) begin
                if (solid_above) m_state = 2;
                else begin
                    v = 4'b1000;
                    m_rise++;
                    if (m_rise == JUMP_H) m_state = 2;
                end
            end else begin
                if (solid_below) m_state = 0;
                else v = 4'b0100;
            end
            m_jp = btn_jump;
            if (btn_left != btn_right) begin
                m_h++;
                if (m_h == H_DIV) begin
                    m_h = 0;
                    if (btn_left && !solid_left)   h = 4'b0010;
                    if (btn_right && !solid_right) h = 4'b0001;
                end
            end else begin
                m_h = 0;
            end
            m_out = v;
            m_sched.push_back(h);
        end
    endfunction

    task automatic run_cyc(input logic tk);
        tick = tk;
        @(posedge sys_clk);
        model_step();
        #1;
        chk_eq("pos", update_pos_scroll, m_out);
        chk_eq("jump", jump, m_state == 1);
        chk_eq("fall", fall, m_state == 2);
        chk_eq("onehot", $countones(update_pos_scroll) <= 1, 1);
        tick = 1'b0;
    endtask

    task automatic tti();
        run_cyc(1'b1);
        repeat (3) run_cyc(1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk_eq("rst_pos", update_pos_scroll, 4'h0);
        chk_eq("rst_jump", jump, 1'b0);
        chk_eq("rst_fall", fall, 1'b0);
        model_reset();
        repeat (2) @(posedge sys_clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // Jump button held through reset must not trigger a jump.
        btn_jump = 1'b1;
        do_reset();
        tti();
        chk_eq("held_no_jump", jump, 1'b0);
        btn_jump = 1'b0; tti();
        btn_jump = 1'b1; tti();
        chk_eq("jump_start", jump, 1'b1);
        repeat (JUMP_H) tti();
        chk_eq("fall_at_apex", fall, 1'b1);
        solid_below = 1'b0; repeat (2) tti();
        solid_below = 1'b1; tti();
        chk_eq("landed", fall, 1'b0);

        // Ceiling bump after one up step.
        btn_jump = 1'b0; tti();
        btn_jump = 1'b1; tti();
        tti();
        solid_above = 1'b1; tti();
        chk_eq("ceiling_fall", fall, 1'b1);
        solid_above = 1'b0; tti();
        chk_eq("ceiling_land", fall, 1'b0);

        // Walking right, open then blocked.
        btn_jump = 1'b0; btn_right = 1'b1;
        repeat (6) tti();
        solid_right = 1'b1; repeat (4) tti();
        solid_right = 1'b0;

        // Both horizontal buttons, then walk-off with a jump edge.
        btn_left = 1'b1; repeat (4) tti();
        btn_left = 1'b0; btn_right = 1'b0;
        btn_jump = 1'b1; solid_below = 1'b0; tti();
        chk_eq("walkoff_fall", fall, 1'b1);
        chk_eq("walkoff_no_rise", jump, 1'b0);

        // Back-to-back ticks while falling and walking.
        btn_jump = 1'b0; btn_right = 1'b1;
        run_cyc(1'b1); run_cyc(1'b1); repeat (3) run_cyc(1'b0);
        run_cyc(1'b1); run_cyc(1'b1); repeat (3) run_cyc(1'b0);
        solid_below = 1'b1; btn_right = 1'b0; tti();

        for (int it = 0; it < 1500; it++) begin
            if ($urandom_range(0, 149) == 0) do_reset();
            btn_left    = ($urandom_range(0, 2) == 0);
            btn_right   = ($urandom_range(0, 2) == 0);
            btn_jump    = $urandom_range(0, 1);
            solid_below = ($urandom_range(0, 2) != 0);
            solid_above = ($urandom_range(0, 9) == 0);
            solid_left  = ($urandom_range(0, 3) == 0);
            solid_right = ($urandom_range(0, 3) == 0);
            run_cyc(1'b1);
            if ($urandom_range(0, 9) == 0) run_cyc(1'b1);
            for (int k = 0; k < int'($urandom_range(2, 5)); k++) begin
                btn_jump    = $urandom_range(0, 1);
                solid_below = $urandom_range(0, 1);
                btn_left    = $urandom_range(0, 1);
                run_cyc(1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
